// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: counter encodings, FSM
// state type and PC index/tag extraction helpers.
package branch_target_buffer_pkg;

    localparam int unsigned CTRL_W   = 2;
    localparam int unsigned PC_MAX_W = 64;

    localparam logic [CTRL_W-1:0] CC_SNT = 2'b00;
    localparam logic [CTRL_W-1:0] CC_WNT = 2'b01;
    localparam logic [CTRL_W-1:0] CC_WT  = 2'b10;
    localparam logic [CTRL_W-1:0] CC_ST  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_INVAL = 1'b1
    } btb_state_t;

    // Word-aligned index: PC[idx_w+1:2], where idx_w = clog2(entries)
    function automatic logic [PC_MAX_W-1:0] btb_index(input logic [PC_MAX_W-1:0] pc,
                                                      input int unsigned entries);
        int unsigned idx_w;
        idx_w = $clog2(entries);
        return (pc >> 2) & ((PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1));
    endfunction

    // Tag: everything above the index bits
    function automatic logic [PC_MAX_W-1:0] btb_tag(input logic [PC_MAX_W-1:0] pc,
                                                    input int unsigned entries);
        int unsigned idx_w;
        idx_w = $clog2(entries);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Predictor interface between the branch unit (master) and the BTB (slave).
interface branch_target_buffer_if #(
    parameter int unsigned PC_W = 32
);
    import branch_target_buffer_pkg::*;

    logic [PC_W-1:0]   i_Fetch_PC;
    logic              o_PcMatchValid;
    logic [PC_W-1:0]   o_Pred_Target;
    logic [CTRL_W-1:0] o_Ctrl;
    logic              o_Pred_Taken;
    logic              i_WriteEnable;
    logic [PC_W-1:0]   i_Upd_PC;
    logic [PC_W-1:0]   i_Upd_Target;
    logic [CTRL_W-1:0] i_CtrlOut;
    logic              i_Invalidate;
    logic              o_Busy;

    modport master (
        output i_Fetch_PC, i_WriteEnable, i_Upd_PC, i_Upd_Target, i_CtrlOut, i_Invalidate,
        input  o_PcMatchValid, o_Pred_Target, o_Ctrl, o_Pred_Taken, o_Busy
    );

    modport slave (
        input  i_Fetch_PC, i_WriteEnable, i_Upd_PC, i_Upd_Target, i_CtrlOut, i_Invalidate,
        output o_PcMatchValid, o_Pred_Target, o_Ctrl, o_Pred_Taken, o_Busy
    );

endinterface

// File: rtl/branch_target_buffer_entry_array.sv
// Registered BTB storage: one combinational read port, one write port and a
// per-entry valid clear. Only the valid bits are reset.
module branch_target_buffer_entry_array
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 26,
    parameter int unsigned PC_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [PC_W-1:0]   rd_target,
    output logic [CTRL_W-1:0] rd_ctrl,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [PC_W-1:0]   wr_target,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [CTRL_W-1:0]  ctrl_q   [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_idx] <= 1'b0;
            if (wr_en)  valid_q[wr_idx]  <= 1'b1;
        end
    end

    // Payload fields carry no reset; they are qualified by valid_q
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctrl_q[wr_idx]   <= wr_ctrl;
        end
    end

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctrl   = ctrl_q[rd_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF lookup, EX update and
// a sequential full-table invalidate walk.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_W    = 32
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    branch_target_buffer_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    btb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              wr_en, clr_en;

    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [TAG_W-1:0]  fetch_tag, wr_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [PC_W-1:0]   rd_target;
    logic [CTRL_W-1:0] rd_ctrl;
    logic              hit;

    assign rd_idx    = IDX_W'(btb_index(PC_MAX_W'(bus.i_Fetch_PC), ENTRIES));
    assign fetch_tag = TAG_W'(btb_tag(PC_MAX_W'(bus.i_Fetch_PC), ENTRIES));
    assign wr_idx    = IDX_W'(btb_index(PC_MAX_W'(bus.i_Upd_PC), ENTRIES));
    assign wr_tag    = TAG_W'(btb_tag(PC_MAX_W'(bus.i_Upd_PC), ENTRIES));

    branch_target_buffer_entry_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .PC_W    (PC_W)
    ) u_entry_array (
        .clk       (i_Clk),
        .rst_n     (i_Rst_n),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctrl   (rd_ctrl),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_target (bus.i_Upd_Target),
        .wr_ctrl   (bus.i_CtrlOut),
        .clr_en    (clr_en),
        .clr_idx   (ptr_q)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Invalidate wins over a coincident update; updates during the walk are lost
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Invalidate) begin
                    state_d = ST_INVAL;
                    ptr_d   = '0;
                end else begin
                    wr_en = bus.i_WriteEnable;
                end
            end
            ST_INVAL: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hit = rd_valid && (rd_tag == fetch_tag) && (state_q == ST_IDLE);

    assign bus.o_PcMatchValid = hit;
    assign bus.o_Pred_Target  = hit ? rd_target : '0;
    assign bus.o_Ctrl         = hit ? rd_ctrl : CC_WNT;
    assign bus.o_Pred_Taken   = hit && rd_ctrl[1];
    assign bus.o_Busy         = (state_q == ST_INVAL);

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer for the 5-stage core, at the far end of the branch unit's predictor interface. In IF it looks up the fetch PC and returns hit, predicted target and the 2-bit saturating counter. The branch unit later returns `WriteEnable`/`CtrlOut`/target from EX, and this block stores that update. It also runs a sequential invalidate walk for context switches and self-modifying-code flushes.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; power of two, ≥ 2.
- `PC_W`, 32: PC width. The index uses `PC[IDX_W+1:2]`; the tag is `PC[PC_W-1:IDX_W+2]`.

Ports (one clock; reset is synchronous and active-low):
- `i_Clk` in 1: clock; all state updates on the rising edge.
- `i_Rst_n` in 1: synchronous active-low reset.
- `i_Fetch_PC` in `PC_W`: IF-stage PC for lookup.
- `o_PcMatchValid` out 1: lookup hit (valid entry with matching tag).
- `o_Pred_Target` out `PC_W`: stored target on a hit; 0 on a miss.
- `o_Ctrl` out 2: stored counter on a hit; `2'b01` on a miss.
- `o_Pred_Taken` out 1: `o_PcMatchValid & o_Ctrl[1]`.
- `i_WriteEnable` in 1: update request from the branch unit (EX).
- `i_Upd_PC` in `PC_W`: PC of the resolved branch/jump.
- `i_Upd_Target` in `PC_W`: resolved target.
- `i_CtrlOut` in 2: new counter value computed by the branch unit.
- `i_Invalidate` in 1: one-cycle pulse that starts a full-table invalidate.
- `o_Busy` out 1: high while the invalidate walk runs.

## Operation
- Storage: `valid[ENTRIES]`, `tag[ENTRIES]`, `target[ENTRIES]`, `ctrl[ENTRIES]`.
- Lookup is combinational from the registered table. A hit requires `valid[idx] & tag[idx]==tag(i_Fetch_PC)` and FSM in IDLE.
- Update, when `i_WriteEnable` is high and the FSM is in IDLE:
  - Writes `valid=1`, `tag`, `target`, `ctrl=i_CtrlOut` at `idx(i_Upd_PC)`.
  - A tag mismatch overwrites the entry (allocate/replace); there is no merge.
  - The block stores `i_CtrlOut` verbatim; saturation is the branch unit's job.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- FSM states are IDLE and INVAL; the walk pointer `ptr` is `IDX_W` bits.
  - IDLE → INVAL on `i_Invalidate`; `ptr` ← 0.
  - INVAL: each cycle clears `valid[ptr]` and increments `ptr`.
  - INVAL → IDLE after clearing entry `ENTRIES-1`; the walk takes exactly `ENTRIES` cycles.
  - `i_Invalidate` is ignored while in INVAL; there is no restart.
- While in INVAL:
  - All lookups miss.
  - `i_WriteEnable` is dropped (the update is lost, not queued).
- Simultaneous `i_Invalidate` and `i_WriteEnable` in IDLE: the update is dropped and the walk starts.
- Reset (`!i_Rst_n` at an edge):
  - All `valid` ← 0, FSM ← IDLE, `ptr` ← 0.
  - `tag`/`target`/`ctrl` are not reset.
  - Reset mid-walk aborts the walk; the table is fully invalid one cycle later.
- Reset output values: `o_PcMatchValid`=0, `o_Pred_Target`=0, `o_Ctrl`=01, `o_Pred_Taken`=0, `o_Busy`=0.

## Timing
- Lookup: zero-cycle combinational from `i_Fetch_PC` to all prediction outputs.
- Update: written at the edge where it is sampled; visible to lookups from the next cycle.
  - A same-cycle lookup of the same index sees the old contents; there is no bypass.
- `o_Busy` rises the cycle after the `i_Invalidate` edge.
  - It stays high for `ENTRIES` cycles, then falls.
  - The first post-walk lookup or update is accepted the cycle after `o_Busy` falls.
- No stall input: IF stall simply holds `i_Fetch_PC`, and the outputs stay stable.

## Structure
- Shared core package holds:
  - Counter encoding constants `CC_SNT`, `CC_WNT`, `CC_WT`, `CC_ST`.
  - FSM state typedef `btb_state_t`.
  - Index/tag extraction functions parameterised on `ENTRIES`.
- One natural sub-module, `btb_entry_array`: registered valid/tag/target/ctrl storage with one read port, one write port and a per-entry valid clear.
  - The FSM and hit logic stay in the top level.

## Test plan
- Reset, then lookup `PC=0x100` → `o_PcMatchValid`=0, `o_Ctrl`=01, `o_Pred_Taken`=0, `o_Busy`=0.
- Update `PC=0x100`, target `0x200`, ctrl 10; lookup `0x100` the next cycle → hit, target `0x200`, `o_Pred_Taken`=1.
  - A same-cycle lookup returns a miss.
- With `ENTRIES`=16, store `0x100`, then update `0x140` (same index, different tag) → lookup `0x100` misses; lookup `0x140` hits.
- Fill 4 entries, pulse `i_Invalidate` → `o_Busy` high for exactly 16 cycles; all lookups miss during and after.
  - An update issued during the walk is absent afterwards.
- Pulse `i_Invalidate` together with `i_WriteEnable` → the update is dropped.
  - A second `i_Invalidate` at cycle 5 of the walk does not extend `o_Busy`.
- Assert `i_Rst_n`=0 at cycle 8 of a walk → next cycle `o_Busy`=0, and every previously valid entry misses.
